// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad scanner and its consumers.
package keypad_pkg;
    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

    localparam logic [3:0] KEY_LEFT  = 4'h1;
    localparam logic [3:0] KEY_DOWN  = 4'h2;
    localparam logic [3:0] KEY_RIGHT = 4'h3;
    localparam logic [3:0] KEY_UP    = 4'h6;

    // Index of the lowest zero bit; callers guarantee at least one zero.
    function automatic logic [1:0] lowest_zero(input logic [3:0] v);
        if (!v[0])      return 2'd0;
        else if (!v[1]) return 2'd1;
        else if (!v[2]) return 2'd2;
        else            return 2'd3;
    endfunction
endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider: one-clk tick every SCAN_DIV clocks plus a scan_clk square wave.
module scan_tick_gen #(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick,
    output logic scan_clk
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DW-1:0] div;

    assign tick = (div == DW'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div      <= '0;
            scan_clk <= 1'b0;
        end else begin
            div <= tick ? '0 : div + 1'b1;
            if (tick) scan_clk <= ~scan_clk;
        end
    end
endmodule

// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad scanner: column rotation, row sync, press/release debounce, registered key outputs.
module keypad_scan_debounce
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int DEB_TICKS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] code,
    output logic       keydown,
    output logic       scan_clk
);
    localparam int CW = $clog2(DEB_TICKS + 1);

    logic          tick;
    logic [3:0]    rs_meta, rs;
    state_t        state, state_nx;
    logic [1:0]    r_idx, c_idx, r_nx, c_nx;
    logic [CW-1:0] cnt, cnt_nx, cnt_inc;
    logic [3:0]    col_nx, code_nx;
    logic          keydown_nx;
    logic          key_low;

    scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .scan_clk (scan_clk)
    );

    assign key_low = ~rs[r_idx];
    assign cnt_inc = (cnt == CW'(DEB_TICKS)) ? cnt : cnt + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rs_meta <= 4'hF;
            rs      <= 4'hF;
            state   <= SCAN;
            col     <= 4'b1110;
            code    <= 4'h0;
            keydown <= 1'b0;
            r_idx   <= 2'd0;
            c_idx   <= 2'd0;
            cnt     <= '0;
        end else begin
            rs_meta <= row;
            rs      <= rs_meta;
            state   <= state_nx;
            col     <= col_nx;
            code    <= code_nx;
            keydown <= keydown_nx;
            r_idx   <= r_nx;
            c_idx   <= c_nx;
            cnt     <= cnt_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        col_nx     = col;
        code_nx    = code;
        keydown_nx = keydown;
        r_nx       = r_idx;
        c_nx       = c_idx;
        cnt_nx     = cnt;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (rs == 4'hF) begin
                        col_nx = {col[2:0], col[3]};
                    end else begin
                        c_nx     = lowest_zero(col);
                        r_nx     = lowest_zero(rs);
                        cnt_nx   = CW'(1);
                        state_nx = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (key_low) begin
                        if (cnt_inc == CW'(DEB_TICKS)) begin
                            code_nx    = {r_idx, c_idx};
                            keydown_nx = 1'b1;
                            cnt_nx     = '0;
                            state_nx   = HELD;
                        end else begin
                            cnt_nx = cnt_inc;
                        end
                    end else begin
                        // Bounce before acceptance: give up and move on to the next column.
                        col_nx   = {col[2:0], col[3]};
                        cnt_nx   = '0;
                        state_nx = SCAN;
                    end
                end
                HELD: begin
                    if (!key_low) begin
                        if (cnt_inc == CW'(DEB_TICKS)) begin
                            keydown_nx = 1'b0;
                            cnt_nx     = '0;
                            state_nx   = SCAN;
                        end else begin
                            cnt_nx = cnt_inc;
                        end
                    end else begin
                        cnt_nx = '0;
                    end
                end
                default: begin
                    cnt_nx   = '0;
                    state_nx = SCAN;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Randomized bench for keypad_scan_debounce against a tick-level behavioural model.
module tb_keypad_scan_debounce;
    import keypad_pkg::*;

    localparam int SCAN_DIV  = 4;
    localparam int DEB_TICKS = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col, code;
    logic        keydown, scan_clk;
    logic [15:0] pressed = '0;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    keypad_scan_debounce #(.SCAN_DIV(SCAN_DIV), .DEB_TICKS(DEB_TICKS)) dut (
        .clk      (clk),
        .rst      (rst),
        .row      (row),
        .col      (col),
        .code     (code),
        .keydown  (keydown),
        .scan_clk (scan_clk)
    );

    always #5 clk = ~clk;

    // Keypad: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[4*r+c] && !col[c]) row[r] = 1'b0;
    end

    // Behavioural model, evaluated once per clock edge.
    int         m_edges = 0, m_ticks = 0, m_colpos = 0, m_run = 0, m_r = 0, m_c = 0;
    bit         m_capt = 0, m_acc = 0, m_kd = 0;
    logic [3:0] m_code = 4'h0, h1 = 4'hF, h2 = 4'hF;

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_edges = 0; m_ticks = 0; m_colpos = 0; m_run = 0;
                m_capt = 0; m_acc = 0; m_kd = 0; m_code = 4'h0;
                h1 = 4'hF; h2 = 4'hF;
            end else begin
                logic [3:0] rs_now;
                rs_now = h2;
                h2 = h1;
                h1 = row;
                m_edges++;
                if (m_edges % SCAN_DIV == 0) begin
                    m_ticks++;
                    if (!m_capt) begin
                        if (rs_now == 4'hF) m_colpos = (m_colpos + 1) % 4;
                        else begin
                            m_capt = 1; m_acc = 0; m_c = m_colpos; m_run = 1;
                            for (int i = 3; i >= 0; i--) if (!rs_now[i]) m_r = i;
                        end
                    end else if (!m_acc) begin
                        if (!rs_now[m_r]) begin
                            m_run++;
                            if (m_run == DEB_TICKS) begin
                                m_acc = 1; m_kd = 1; m_run = 0;
                                m_code = 4'(4*m_r + m_c);
                            end
                        end else begin
                            m_capt = 0;
                            m_colpos = (m_colpos + 1) % 4;
                        end
                    end else begin
                        if (rs_now[m_r]) begin
                            m_run++;
                            if (m_run == DEB_TICKS) begin
                                m_kd = 0; m_capt = 0; m_acc = 0; m_run = 0;
                            end
                        end else m_run = 0;
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h want=%h at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("col",      col,              ~(4'b0001 << m_colpos));
            chk("code",     code,             m_code);
            chk("keydown",  {3'b0, keydown},  {3'b0, m_kd});
            chk("scan_clk", {3'b0, scan_clk}, {3'b0, 1'(m_ticks % 2)});
        end
    end

    task automatic ticks(input int n);
        repeat (n * SCAN_DIV) @(negedge clk);
    endtask

    task automatic wait_kd(input logic v, input int max_ticks, input string nm);
        int k;
        k = 0;
        while (keydown !== v && k < max_ticks * SCAN_DIV) begin
            @(negedge clk);
            k++;
        end
        chk(nm, {3'b0, keydown}, {3'b0, v});
    endtask

    task automatic wait_col(input logic [3:0] target, input string nm);
        int k;
        k = 0;
        while (col !== target && k < 8 * SCAN_DIV) begin
            @(negedge clk);
            k++;
        end
        chk(nm, col, target);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        chk("rst_col", col, 4'b1110);
        chk("rst_code", code, 4'h0);
        chk("rst_kd", {3'b0, keydown}, 4'h0);
        chk("rst_sclk", {3'b0, scan_clk}, 4'h0);
        rst = 1'b1;

        // 1: idle rotation
        repeat (4) @(negedge clk);
        chk("idle_col1", col, 4'b1101);
        chk("idle_sclk1", {3'b0, scan_clk}, 4'h1);
        repeat (4) @(negedge clk);
        chk("idle_col2", col, 4'b1011);
        chk("idle_sclk2", {3'b0, scan_clk}, 4'h0);
        ticks(4);

        // 2: clean press r0c1
        pressed = 16'h0002;
        wait_kd(1'b1, 20, "press_r0c1");
        chk("code_r0c1", code, KEY_LEFT);
        ticks(20);
        pressed = '0;
        ticks(6);
        chk("rel_r0c1_kd", {3'b0, keydown}, 4'h0);
        chk("rel_r0c1_code", code, KEY_LEFT);

        // 3: press bounce on r1c2
        wait_col(4'b1011, "col_for_r1c2");
        pressed = 16'h0040;
        ticks(2);
        pressed = '0;
        ticks(1);
        chk("bounce_no_kd", {3'b0, keydown}, 4'h0);
        pressed = 16'h0040;
        wait_kd(1'b1, 20, "press_r1c2");
        chk("code_r1c2", code, KEY_UP);
        pressed = '0;
        wait_kd(1'b0, 8, "rel_r1c2");

        // 4: extra keys while r0c3 is held
        wait_col(4'b0111, "col_for_r0c3");
        pressed = 16'h0008;
        wait_kd(1'b1, 20, "press_r0c3");
        pressed = 16'h0809;
        ticks(5);
        chk("multi_code", code, KEY_RIGHT);
        chk("multi_col", col, 4'b0111);
        chk("multi_kd", {3'b0, keydown}, 4'h1);
        pressed = 16'h0801;
        wait_kd(1'b0, 6, "rel_r0c3");
        pressed = '0;
        ticks(8);

        // 5: release bounce on r0c2
        wait_col(4'b1011, "col_for_r0c2");
        pressed = 16'h0004;
        wait_kd(1'b1, 20, "press_r0c2");
        ticks(3);
        pressed = '0;
        ticks(2);
        pressed = 16'h0004;
        ticks(1);
        pressed = '0;
        chk("relbounce_kd", {3'b0, keydown}, 4'h1);
        ticks(6);
        chk("relbounce_done", {3'b0, keydown}, 4'h0);
        chk("relbounce_code", code, KEY_DOWN);

        // 6: asynchronous reset while held
        pressed = 16'h0001;
        wait_kd(1'b1, 20, "press_r0c0");
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_kd", {3'b0, keydown}, 4'h0);
        chk("arst_code", code, 4'h0);
        chk("arst_col", col, 4'b1110);
        pressed = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_col", col, 4'b1101);

        // Randomized presses, releases, bounces and extra keys
        for (int it = 0; it < 60; it++) begin
            int k;
            k = $urandom_range(15);
            ticks($urandom_range(0, 4));
            pressed = 16'(1) << k;
            if ($urandom_range(3) == 0) pressed[$urandom_range(15)] = 1'b1;
            if ($urandom_range(2) == 0) begin
                repeat ($urandom_range(2, 10)) begin
                    @(negedge clk);
                    pressed[k] = 1'($urandom_range(1));
                end
                pressed[k] = 1'b1;
            end
            ticks($urandom_range(1, 12));
            pressed = '0;
            ticks($urandom_range(0, 8));
        end
        pressed = '0;
        ticks(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
